// File: rtl/mcu_el2_pkg.sv
// rtl/mcu_el2_pkg.sv - shared state type and constants for the DCCM init controller
package mcu_el2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        INIT   = 2'd1,
        VERIFY = 2'd2,
        DONE   = 2'd3
    } mcu_el2_dccm_init_state_t;

    localparam logic [6:0] DCCM_INIT_ECC = 7'h00;

endpackage

// File: rtl/mcu_el2_dccm_init_mux.sv
// rtl/mcu_el2_dccm_init_mux.sv - per-bank SRAM port mux between core traffic and the init engine
module mcu_el2_dccm_init_mux #(
    parameter int AW = 10,
    parameter int DW = 32,
    parameter int EW = 7
) (
    input  logic          i_sel,
    input  logic          i_init_clken,
    input  logic          i_init_wren,
    input  logic [AW-1:0] i_init_addr,
    input  logic [EW-1:0] i_init_ecc,
    input  logic          i_core_clken,
    input  logic          i_core_wren,
    input  logic [AW-1:0] i_core_addr,
    input  logic [DW-1:0] i_core_wr_data,
    input  logic [EW-1:0] i_core_wr_ecc,
    output logic [DW-1:0] o_core_dout,
    output logic [EW-1:0] o_core_ecc,
    output logic          o_sram_clken,
    output logic          o_sram_wren,
    output logic [AW-1:0] o_sram_addr,
    output logic [DW-1:0] o_sram_wr_data,
    output logic [EW-1:0] o_sram_wr_ecc,
    input  logic [DW-1:0] i_sram_dout,
    input  logic [EW-1:0] i_sram_ecc
);

    // Init engine always writes zero data, so it needs no data input.
    assign o_sram_clken   = i_sel ? i_init_clken : i_core_clken;
    assign o_sram_wren    = i_sel ? i_init_wren  : i_core_wren;
    assign o_sram_addr    = i_sel ? i_init_addr  : i_core_addr;
    assign o_sram_wr_data = i_sel ? '0           : i_core_wr_data;
    assign o_sram_wr_ecc  = i_sel ? i_init_ecc   : i_core_wr_ecc;
    assign o_core_dout    = i_sel ? '0           : i_sram_dout;
    assign o_core_ecc     = i_sel ? '0           : i_sram_ecc;

endmodule

// File: rtl/mcu_el2_dccm_init_ctrl.sv
// rtl/mcu_el2_dccm_init_ctrl.sv - DCCM zero/ECC initialiser with core pass-through; MCU_DCCM_INIT_VERIFY_EN adds read-back verify
module mcu_el2_dccm_init_ctrl
    import mcu_el2_pkg::*;
#(
    parameter int               NUM_BANKS = 4,
    parameter int               BANK_AW   = 10,
    parameter int               DATA_W    = 32,
    parameter int               ECC_W     = 7,
    parameter logic [ECC_W-1:0] INIT_ECC  = DCCM_INIT_ECC,
    parameter bit               AUTO_INIT = 1'b1
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_init_req,
    output logic                         o_init_busy,
    output logic                         o_init_done,
    output logic                         o_init_err,
    output logic                         o_core_stall,
    input  logic [NUM_BANKS-1:0]         i_core_clken,
    input  logic [NUM_BANKS-1:0]         i_core_wren,
    input  logic [NUM_BANKS*BANK_AW-1:0] i_core_addr,
    input  logic [NUM_BANKS*DATA_W-1:0]  i_core_wr_data,
    input  logic [NUM_BANKS*ECC_W-1:0]   i_core_wr_ecc,
    output logic [NUM_BANKS*DATA_W-1:0]  o_core_dout,
    output logic [NUM_BANKS*ECC_W-1:0]   o_core_ecc,
    output logic [NUM_BANKS-1:0]         o_sram_clken,
    output logic [NUM_BANKS-1:0]         o_sram_wren,
    output logic [NUM_BANKS*BANK_AW-1:0] o_sram_addr,
    output logic [NUM_BANKS*DATA_W-1:0]  o_sram_wr_data,
    output logic [NUM_BANKS*ECC_W-1:0]   o_sram_wr_ecc,
    input  logic [NUM_BANKS*DATA_W-1:0]  i_sram_dout,
    input  logic [NUM_BANKS*ECC_W-1:0]   i_sram_ecc
);

    mcu_el2_dccm_init_state_t r_state, w_next;
    logic [BANK_AW-1:0]       r_cnt;
    logic                     w_busy;
    logic                     w_drain;
    logic                     w_init_clken;
    logic                     w_init_wren;

    assign w_busy       = (r_state == INIT) || (r_state == VERIFY);
    assign o_init_busy  = w_busy;
    assign o_core_stall = w_busy;
    assign o_init_done  = (r_state == DONE);

`ifdef MCU_DCCM_INIT_VERIFY_EN
    logic r_vld;
    logic r_err;
    logic w_mismatch;

    // The drain cycle is the only VERIFY cycle that sees a wrapped counter with read data pending.
    assign w_drain    = (r_state == VERIFY) && r_vld && (r_cnt == '0);
    assign w_mismatch = (i_sram_dout != '0) || (i_sram_ecc != {NUM_BANKS{INIT_ECC}});
    assign o_init_err = r_err;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_vld <= 1'b0;
            r_err <= 1'b0;
        end else begin
            r_vld <= (r_state == VERIFY) && !w_drain;
            if (i_init_req && !w_busy)
                r_err <= 1'b0;
            else if (r_vld && w_mismatch)
                r_err <= 1'b1;
        end
    end
`else
    assign w_drain    = 1'b0;
    assign o_init_err = 1'b0;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= AUTO_INIT ? INIT : IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (w_busy && !w_drain)
                r_cnt <= r_cnt + 1'b1;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_init_clken = 1'b0;
        w_init_wren  = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                if (i_init_req)
                    w_next = INIT;
            end
            INIT: begin
                w_init_clken = 1'b1;
                w_init_wren  = 1'b1;
                if (r_cnt == '1)
`ifdef MCU_DCCM_INIT_VERIFY_EN
                    w_next = VERIFY;
`else
                    w_next = DONE;
`endif
            end
`ifdef MCU_DCCM_INIT_VERIFY_EN
            VERIFY: begin
                if (w_drain)
                    w_next = DONE;
                else
                    w_init_clken = 1'b1;
            end
`endif
            default: w_next = IDLE;
        endcase
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        mcu_el2_dccm_init_mux #(
            .AW(BANK_AW),
            .DW(DATA_W),
            .EW(ECC_W)
        ) u_mux (
            .i_sel          (w_busy),
            .i_init_clken   (w_init_clken),
            .i_init_wren    (w_init_wren),
            .i_init_addr    (r_cnt),
            .i_init_ecc     (INIT_ECC),
            .i_core_clken   (i_core_clken[b]),
            .i_core_wren    (i_core_wren[b]),
            .i_core_addr    (i_core_addr[b*BANK_AW +: BANK_AW]),
            .i_core_wr_data (i_core_wr_data[b*DATA_W +: DATA_W]),
            .i_core_wr_ecc  (i_core_wr_ecc[b*ECC_W +: ECC_W]),
            .o_core_dout    (o_core_dout[b*DATA_W +: DATA_W]),
            .o_core_ecc     (o_core_ecc[b*ECC_W +: ECC_W]),
            .o_sram_clken   (o_sram_clken[b]),
            .o_sram_wren    (o_sram_wren[b]),
            .o_sram_addr    (o_sram_addr[b*BANK_AW +: BANK_AW]),
            .o_sram_wr_data (o_sram_wr_data[b*DATA_W +: DATA_W]),
            .o_sram_wr_ecc  (o_sram_wr_ecc[b*ECC_W +: ECC_W]),
            .i_sram_dout    (i_sram_dout[b*DATA_W +: DATA_W]),
            .i_sram_ecc     (i_sram_ecc[b*ECC_W +: ECC_W])
        );
    end

endmodule

// File: tb/tb_mcu_el2_dccm_init_ctrl.sv
// tb/tb_mcu_el2_dccm_init_ctrl.sv - scoreboard bench for the DCCM init controller (MCU_DCCM_INIT_VERIFY_EN aware)
module tb_mcu_el2_dccm_init_ctrl;

    localparam int NB = 4;
    localparam int AW = 4;
    localparam int DW = 32;
    localparam int EW = 7;
`ifdef MCU_DCCM_INIT_VERIFY_EN
    localparam int  PASS_CYC  = 2 * (1 << AW) + 1;
    localparam logic FIRST_ERR = 1'b1;
`else
    localparam int  PASS_CYC  = 1 << AW;
    localparam logic FIRST_ERR = 1'b0;
`endif

    typedef struct packed {
        logic [NB-1:0]    wren;
        logic [NB*AW-1:0] addr;
        logic [NB*DW-1:0] data;
        logic [NB*EW-1:0] ecc;
    } wr_t;

    logic clk, rst, init_req;
    logic init_busy, init_done, init_err, core_stall;
    logic [NB-1:0]    core_clken, core_wren, sram_clken, sram_wren;
    logic [NB*AW-1:0] core_addr, sram_addr;
    logic [NB*DW-1:0] core_wr_data, core_dout, sram_wr_data, sram_dout;
    logic [NB*EW-1:0] core_wr_ecc, core_ecc, sram_wr_ecc, sram_ecc;

    int  total = 0;
    int  bad   = 0;
    wr_t sb_q[$];
    logic corrupt_en;

    logic [DW-1:0] m_data [NB][1 << AW];
    logic [EW-1:0] m_ecc  [NB][1 << AW];

    mcu_el2_dccm_init_ctrl #(
        .NUM_BANKS(NB), .BANK_AW(AW), .DATA_W(DW), .ECC_W(EW),
        .INIT_ECC(7'h00), .AUTO_INIT(1'b1)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_init_req(init_req),
        .o_init_busy(init_busy), .o_init_done(init_done), .o_init_err(init_err),
        .o_core_stall(core_stall),
        .i_core_clken(core_clken), .i_core_wren(core_wren), .i_core_addr(core_addr),
        .i_core_wr_data(core_wr_data), .i_core_wr_ecc(core_wr_ecc),
        .o_core_dout(core_dout), .o_core_ecc(core_ecc),
        .o_sram_clken(sram_clken), .o_sram_wren(sram_wren), .o_sram_addr(sram_addr),
        .o_sram_wr_data(sram_wr_data), .o_sram_wr_ecc(sram_wr_ecc),
        .i_sram_dout(sram_dout), .i_sram_ecc(sram_ecc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM bank model with one-cycle read latency and an optional ECC fault.
    always @(posedge clk) begin
        for (int b = 0; b < NB; b++) begin
            if (sram_clken[b]) begin
                if (sram_wren[b]) begin
                    m_data[b][sram_addr[b*AW +: AW]] <= sram_wr_data[b*DW +: DW];
                    m_ecc[b][sram_addr[b*AW +: AW]]  <= (corrupt_en && b == 1 && sram_addr[b*AW +: AW] == 4'd9)
                                                        ? 7'h01 : sram_wr_ecc[b*EW +: EW];
                end else begin
                    sram_dout[b*DW +: DW] <= m_data[b][sram_addr[b*AW +: AW]];
                    sram_ecc[b*EW +: EW]  <= m_ecc[b][sram_addr[b*AW +: AW]];
                end
            end
        end
    end

    // Monitor: every SRAM write must match the next expected write.
    always @(negedge clk) begin
        if (!rst && sram_wren != '0) begin
            wr_t act, exp;
            act = '{wren: sram_wren, addr: sram_addr, data: sram_wr_data, ecc: sram_wr_ecc};
            total++;
            if (sb_q.size() == 0) begin
                bad++;
                $display("FAIL sram_write unexpected: wren=%h addr=%h data=%h ecc=%h", act.wren, act.addr, act.data, act.ecc);
            end else begin
                exp = sb_q.pop_front();
                if (act !== exp) begin
                    bad++;
                    $display("FAIL sram_write got wren=%h addr=%h data=%h ecc=%h want wren=%h addr=%h data=%h ecc=%h",
                             act.wren, act.addr, act.data, act.ecc, exp.wren, exp.addr, exp.data, exp.ecc);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic push_init(input int n);
        for (int a = 0; a < n; a++) begin
            logic [AW-1:0] a4;
            a4 = AW'(a);
            sb_q.push_back('{wren: '1, addr: {NB{a4}}, data: '0, ecc: '0});
        end
    endtask

    task automatic core_idle();
        core_clken = '0; core_wren = '0; core_addr = '0; core_wr_data = '0; core_wr_ecc = '0;
    endtask

    task automatic pass_end(input string tag, input logic exp_err);
        repeat (PASS_CYC - 1) @(posedge clk);
        #1 chk({tag, "_busy_last"}, init_busy, 1'b1);
        @(posedge clk);
        #1 chk({tag, "_busy_end"}, init_busy, 1'b0);
        chk({tag, "_done"}, init_done, 1'b1);
        chk({tag, "_err"}, init_err, exp_err);
        chk({tag, "_sb_empty"}, sb_q.size(), 0);
    endtask

    initial begin
        rst = 1'b0; init_req = 1'b0; corrupt_en = 1'b1;
        core_idle();
        #1 rst = 1'b1;
        #2;
        chk("rst_busy", init_busy, 1'b1);
        chk("rst_stall", core_stall, 1'b1);
        chk("rst_done", init_done, 1'b0);
        chk("rst_err", init_err, 1'b0);
        chk("rst_addr", sram_addr, '0);

        // Auto init after reset release.
        repeat (2) @(posedge clk);
        #1 push_init(1 << AW);
        rst = 1'b0;
        pass_end("auto", FIRST_ERR);
        corrupt_en = 1'b0;

        // Pass-through write then read on bank 2, address 5.
        core_clken   = 4'b0100;
        core_wren    = 4'b0100;
        core_addr    = 16'h0500;
        core_wr_data = {32'h0, 32'hDEADBEEF, 64'h0};
        core_wr_ecc  = 28'h3A << 14;
        sb_q.push_back('{wren: 4'b0100, addr: 16'h0500, data: {32'h0, 32'hDEADBEEF, 64'h0}, ecc: 28'h3A << 14});
        #1 chk("pt_sram_addr", sram_addr, core_addr);
        chk("pt_sram_data", sram_wr_data, core_wr_data);
        chk("pt_sram_ecc", sram_wr_ecc, core_wr_ecc);
        @(posedge clk);
        #1 core_wren = '0;
        @(posedge clk);
        #1 chk("pt_dout", core_dout[95:64], 32'hDEADBEEF);
        chk("pt_ecc", core_ecc[20:14], 7'h3A);
        core_idle();

        // Busy blocking: request from DONE, hammer core writes, re-request mid-pass and on the last write.
        chk("done_before_req", init_done, 1'b1);
        push_init(1 << AW);
        init_req = 1'b1;
        @(posedge clk);
        #1 init_req = 1'b0;
        chk("req_done_clr", init_done, 1'b0);
        chk("req_busy_set", init_busy, 1'b1);
        core_clken = '1; core_wren = '1; core_addr = {NB{4'd3}};
        core_wr_data = {NB{32'h1234}}; core_wr_ecc = {NB{7'h55}};
        #1 chk("busy_dout_zero", core_dout, '0);
        chk("busy_ecc_zero", core_ecc, '0);
        for (int c = 1; c < PASS_CYC; c++) begin
            @(posedge clk);
            #1 init_req = (c == 5) || (c == (1 << AW) - 1);
            if (c == 10) core_idle();
            if (c == PASS_CYC - 1) chk("blk_busy_last", init_busy, 1'b1);
        end
        @(posedge clk);
        #1 init_req = 1'b0;
        chk("blk_busy_end", init_busy, 1'b0);
        chk("blk_done", init_done, 1'b1);
        chk("blk_err_clean", init_err, 1'b0);
        chk("blk_sb_empty", sb_q.size(), 0);
        @(posedge clk);
        #1 chk("blk_no_restart", init_busy, 1'b0);

        // Reset mid-pass at INIT cycle 7.
        push_init(7);
        init_req = 1'b1;
        @(posedge clk);
        #1 init_req = 1'b0;
        repeat (7) @(posedge clk);
        #1 rst = 1'b1;
        #1 chk("midrst_addr", sram_addr, '0);
        chk("midrst_busy", init_busy, 1'b1);
        repeat (2) @(posedge clk);
        #1 push_init(1 << AW);
        rst = 1'b0;
        pass_end("restart", 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mcu_el2_dccm_init_ctrl.md
Name: mcu_el2_dccm_init_ctrl

Overview:
- Sits between the DCCM SRAM export port of the MCU memory wrapper and the physical DCCM bank macros.
- After reset, or on request, it writes every word of every bank with zero data and matching ECC, so the first core reads see no ECC errors.
- While initialising, it owns the SRAM ports and stalls the core side. Otherwise it passes core traffic straight through.

Parameters:
- NUM_BANKS, 4, number of DCCM banks.
- BANK_AW, 10, address width per bank (depth = 2**BANK_AW).
- DATA_W, 32, data bits per bank word.
- ECC_W, 7, ECC bits per bank word.
- INIT_ECC, 7'h00, ECC value written alongside zero data.
- AUTO_INIT, 1, start initialisation automatically when reset is released.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-high reset.
- init_req  in  1  one-cycle pulse that starts an initialisation pass.
- init_busy  out  1  high while the block owns the SRAMs.
- init_done  out  1  high from completion until the next init_req.
- init_err  out  1  sticky verify mismatch; only driven under the macro, else tied 0.
- core_stall  out  1  equals init_busy; the core must hold its request while this is high.
- core_clken  in  NUM_BANKS  core bank clock enables.
- core_wren  in  NUM_BANKS  core bank write enables.
- core_addr  in  NUM_BANKS x BANK_AW  core bank addresses.
- core_wr_data  in  NUM_BANKS x DATA_W  core write data.
- core_wr_ecc  in  NUM_BANKS x ECC_W  core write ECC.
- core_dout  out  NUM_BANKS x DATA_W  read data returned to the core.
- core_ecc  out  NUM_BANKS x ECC_W  read ECC returned to the core.
- sram_clken  out  NUM_BANKS  SRAM clock enables.
- sram_wren  out  NUM_BANKS  SRAM write enables.
- sram_addr  out  NUM_BANKS x BANK_AW  SRAM addresses.
- sram_wr_data  out  NUM_BANKS x DATA_W  SRAM write data.
- sram_wr_ecc  out  NUM_BANKS x ECC_W  SRAM write ECC.
- sram_dout  in  NUM_BANKS x DATA_W  SRAM read data, valid one cycle after the read.
- sram_ecc  in  NUM_BANKS x ECC_W  SRAM read ECC, valid one cycle after the read.

Behaviour:
- Reset values:
  - state = INIT if AUTO_INIT, else IDLE.
  - addr counter = 0.
  - init_busy = AUTO_INIT; init_done = 0; init_err = 0.
- States and transitions:
  - IDLE: pass-through. sram_* = core_*, core_dout/core_ecc = sram_dout/sram_ecc, combinational with no added latency. init_req moves to INIT.
  - INIT: all banks get clken=1, wren=1, addr=counter, data=0, ecc=INIT_ECC. Counter increments each cycle. At counter = 2**BANK_AW-1 the counter wraps to 0 and the state goes to DONE (or VERIFY under the macro).
  - DONE: identical to IDLE pass-through, with init_done=1. init_req moves to INIT and clears init_done in the same edge.
- Full pass timing: INIT lasts exactly 2**BANK_AW cycles. init_busy falls on the edge after the last write.
- Core side while busy:
  - core_* inputs are ignored and no core write reaches the SRAM.
  - core_dout and core_ecc read 0.
- init_req while busy: ignored; the counter does not restart.
- init_req in the same cycle as the last INIT write: ignored.
- rst asserted mid-pass: the state and counter return to their reset values asynchronously. A partial pass is abandoned; with AUTO_INIT it restarts from address 0.
- Counter is BANK_AW bits wide. Wrap-around is the only termination condition, with no extra terminal-count register.

Optional Feature:
- Macro: MCU_DCCM_INIT_VERIFY_EN.
- With the macro:
  - After INIT, the state goes to VERIFY. Reads are issued to all banks at counter addresses 0..2**BANK_AW-1 (clken=1, wren=0).
  - A one-cycle-delayed valid flag compares sram_dout==0 and sram_ecc==INIT_ECC for every bank.
  - Any mismatch sets init_err. init_err clears only on rst or the next init_req.
  - One extra drain cycle covers the last read, so VERIFY lasts 2**BANK_AW+1 cycles, then the state goes to DONE.
  - init_busy covers both INIT and VERIFY.
- Without the macro: no VERIFY state and init_err is tied 0.

Decomposition:
- mcu_el2_pkg gets the state enum typedef mcu_el2_dccm_init_state_t (IDLE, INIT, VERIFY, DONE) and the INIT_ECC default constant.
- One sub-module: mcu_el2_dccm_init_mux, a purely combinational per-bank port mux selected by init_busy, instantiated NUM_BANKS times via generate.

Test Plan:
- Auto init:
  - Stimulus: AUTO_INIT=1, BANK_AW=4; release rst.
  - Response: 16 cycles of wren=4'hF at addresses 0..15 with data 0 and ecc 7'h00; init_busy falls at cycle 16; init_done=1.
- Pass-through:
  - Stimulus: in DONE, core writes bank2 addr 5 data 32'hDEADBEEF ecc 7'h3A, then reads it.
  - Response: sram_* mirror core_* in the same cycle; core_dout = 32'hDEADBEEF the next cycle.
- Busy blocking:
  - Stimulus: AUTO_INIT=0; pulse init_req; during INIT drive core_wren=4'hF at addr 3 with data 32'h1234; pulse init_req again at cycle 5.
  - Response: no core data reaches the SRAM; core_dout=0; the pass still ends after 16 cycles with no restart.
- Reset mid-pass:
  - Stimulus: assert rst at cycle 7 of INIT.
  - Response: counter returns to 0 immediately; after release, the pass restarts from address 0 and completes in 16 cycles.
- Verify with macro:
  - Stimulus: define MCU_DCCM_INIT_VERIFY_EN; the SRAM model corrupts bank1 addr 9 ecc to 7'h01.
  - Response: VERIFY lasts 17 cycles; init_err=1 at DONE; the next init_req clears it, and a clean pass leaves init_err=0.
- Done cleared by request:
  - Stimulus: pulse init_req while in DONE.
  - Response: init_done falls and init_busy rises on the next edge.
